// File: rtl/alu_issue_stage.sv
// ALU issue stage: decodes RV32I fields into an ALU operation, selects SrcA/SrcB and
// registers them behind a valid/ready handshake with flush. ALU_ISSUE_SKID_EN adds a skid entry.
module alu_issue_stage #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [6:0]               Opcode,
    input  logic [2:0]               Funct3,
    input  logic [6:0]               Funct7,
    input  logic [DATA_WIDTH-1:0]    RD1,
    input  logic [DATA_WIDTH-1:0]    RD2,
    input  logic [DATA_WIDTH-1:0]    Imm,
    input  logic                     flush,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [DATA_WIDTH-1:0]    SrcA,
    output logic [DATA_WIDTH-1:0]    SrcB,
    output logic [OPCODE_LENGTH-1:0] Operation,
    output logic                     illegal,
    output logic [CNT_WIDTH-1:0]     illegal_count
);
    localparam logic [6:0] OPC_R = 7'b0110011, OPC_I = 7'b0010011, OPC_LD = 7'b0000011;
    localparam logic [6:0] OPC_ST = 7'b0100011, OPC_BR = 7'b1100011, OPC_JALR = 7'b1100111;
    localparam logic [6:0] OPC_LUI = 7'b0110111, F7_ZERO = 7'b0000000, F7_ALT = 7'b0100000;
    localparam logic [OPCODE_LENGTH-1:0] OP_AND = OPCODE_LENGTH'(4'b0000);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD = OPCODE_LENGTH'(4'b0011);

    function automatic logic [OPCODE_LENGTH-1:0] alu_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? OPCODE_LENGTH'(4'b0100) : OPCODE_LENGTH'(4'b0011);
            3'b001:  return OPCODE_LENGTH'(4'b0111);
            3'b010:  return OPCODE_LENGTH'(4'b1010);
            3'b011:  return OPCODE_LENGTH'(4'b1110);
            3'b100:  return OPCODE_LENGTH'(4'b0010);
            3'b101:  return alt ? OPCODE_LENGTH'(4'b0110) : OPCODE_LENGTH'(4'b0101);
            3'b110:  return OPCODE_LENGTH'(4'b0001);
            default: return OPCODE_LENGTH'(4'b0000);
        endcase
    endfunction

    logic [OPCODE_LENGTH-1:0] dec_op;
    logic                     dec_ill;
    logic [DATA_WIDTH-1:0]    dec_b;

    always_comb begin
        dec_op  = OP_AND;
        dec_ill = 1'b0;
        dec_b   = RD2;
        case (Opcode)
            OPC_R: begin
                dec_ill = !(Funct7 == F7_ZERO ||
                            (Funct7 == F7_ALT && (Funct3 == 3'b000 || Funct3 == 3'b101)));
                dec_op  = alu_f3(Funct3, Funct7[5]);
            end
            OPC_I: begin
                dec_b = Imm;
                // Shift-immediates carry the shamt in Imm[4:0]; upper bits hold funct7.
                if (Funct3 == 3'b001 || Funct3 == 3'b101)
                    dec_b = {{(DATA_WIDTH-5){1'b0}}, Imm[4:0]};
                dec_ill = (Funct3 == 3'b001 && Funct7 != F7_ZERO) ||
                          (Funct3 == 3'b101 && Funct7 != F7_ZERO && Funct7 != F7_ALT);
                dec_op  = alu_f3(Funct3, Funct3 == 3'b101 && Funct7[5]);
            end
            OPC_LD, OPC_ST: begin
                dec_b  = Imm;
                dec_op = OP_ADD;
            end
            OPC_LUI: begin
                dec_b  = Imm;
                dec_op = OPCODE_LENGTH'(4'b1101);
            end
            OPC_BR: begin
                case (Funct3)
                    3'b000:  dec_op = OPCODE_LENGTH'(4'b1000);
                    3'b001:  dec_op = OPCODE_LENGTH'(4'b1001);
                    3'b100:  dec_op = OPCODE_LENGTH'(4'b1010);
                    3'b101:  dec_op = OPCODE_LENGTH'(4'b1011);
                    3'b110:  dec_op = OPCODE_LENGTH'(4'b1110);
                    3'b111:  dec_op = OPCODE_LENGTH'(4'b1111);
                    default: dec_ill = 1'b1;
                endcase
            end
            OPC_JALR: begin
                dec_op  = OPCODE_LENGTH'(4'b1100);
                dec_ill = (Funct3 != 3'b000);
            end
            default: dec_ill = 1'b1;
        endcase
        if (dec_ill)
            dec_op = OP_AND;
    end

    logic                     out_valid_q, out_valid_d, illegal_q, illegal_d;
    logic [DATA_WIDTH-1:0]    src_a_q, src_a_d, src_b_q, src_b_d;
    logic [OPCODE_LENGTH-1:0] op_q, op_d;
    logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
    logic                     accept, out_fire;

    assign out_fire = out_valid_q && out_ready;
    assign accept   = in_valid && in_ready && !flush;

`ifdef ALU_ISSUE_SKID_EN
    logic                     skid_full_q, skid_full_d, skid_ill_q, skid_ill_d;
    logic [DATA_WIDTH-1:0]    skid_a_q, skid_a_d, skid_b_q, skid_b_d;
    logic [OPCODE_LENGTH-1:0] skid_op_q, skid_op_d;

    // Registered ready: an accept can only ever land in an empty skid slot.
    assign in_ready = !skid_full_q;
`else
    assign in_ready = !out_valid_q || out_ready;
`endif

    always_comb begin
        out_valid_d = out_valid_q;
        illegal_d   = illegal_q;
        src_a_d     = src_a_q;
        src_b_d     = src_b_q;
        op_d        = op_q;
        cnt_d       = cnt_q;
        if (accept && dec_ill && !(&cnt_q))
            cnt_d = cnt_q + CNT_WIDTH'(1);
`ifdef ALU_ISSUE_SKID_EN
        skid_full_d = skid_full_q;
        skid_ill_d  = skid_ill_q;
        skid_a_d    = skid_a_q;
        skid_b_d    = skid_b_q;
        skid_op_d   = skid_op_q;
        if (flush) begin
            out_valid_d = 1'b0;
            illegal_d   = 1'b0;
            skid_full_d = 1'b0;
        end else if (!out_valid_q || out_fire) begin
            if (skid_full_q) begin
                out_valid_d = 1'b1;
                src_a_d     = skid_a_q;
                src_b_d     = skid_b_q;
                op_d        = skid_op_q;
                illegal_d   = skid_ill_q;
                skid_full_d = 1'b0;
            end else if (accept) begin
                out_valid_d = 1'b1;
                src_a_d     = RD1;
                src_b_d     = dec_b;
                op_d        = dec_op;
                illegal_d   = dec_ill;
            end else begin
                out_valid_d = 1'b0;
            end
        end else if (accept) begin
            skid_full_d = 1'b1;
            skid_a_d    = RD1;
            skid_b_d    = dec_b;
            skid_op_d   = dec_op;
            skid_ill_d  = dec_ill;
        end
`else
        if (flush) begin
            out_valid_d = 1'b0;
            illegal_d   = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            src_a_d     = RD1;
            src_b_d     = dec_b;
            op_d        = dec_op;
            illegal_d   = dec_ill;
        end else if (out_fire) begin
            out_valid_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid_q <= 1'b0;
            illegal_q   <= 1'b0;
            src_a_q     <= '0;
            src_b_q     <= '0;
            op_q        <= '0;
            cnt_q       <= '0;
`ifdef ALU_ISSUE_SKID_EN
            skid_full_q <= 1'b0;
            skid_ill_q  <= 1'b0;
            skid_a_q    <= '0;
            skid_b_q    <= '0;
            skid_op_q   <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            illegal_q   <= illegal_d;
            src_a_q     <= src_a_d;
            src_b_q     <= src_b_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
`ifdef ALU_ISSUE_SKID_EN
            skid_full_q <= skid_full_d;
            skid_ill_q  <= skid_ill_d;
            skid_a_q    <= skid_a_d;
            skid_b_q    <= skid_b_d;
            skid_op_q   <= skid_op_d;
`endif
        end
    end

    assign out_valid     = out_valid_q;
    assign SrcA          = src_a_q;
    assign SrcB          = src_b_q;
    assign Operation     = op_q;
    assign illegal       = illegal_q;
    assign illegal_count = cnt_q;
endmodule

// File: tb/tb_alu_issue_stage.sv
// Bench for alu_issue_stage: directed scenarios plus a randomized run against a queue-based model.
module tb_alu_issue_stage;
    logic        clk = 1'b0, reset = 1'b0;
    logic        in_valid = 1'b0, flush = 1'b0, out_ready = 1'b1;
    logic [6:0]  Opcode = '0, Funct7 = '0;
    logic [2:0]  Funct3 = '0;
    logic [31:0] RD1 = '0, RD2 = '0, Imm = '0;
    logic        in_ready, out_valid, illegal;
    logic [31:0] SrcA, SrcB;
    logic [3:0]  Operation;
    logic [7:0]  illegal_count;
    logic        in_ready2, out_valid2, illegal2;
    logic [31:0] SrcA2, SrcB2;
    logic [3:0]  Operation2;
    logic [1:0]  illegal_count2;

    int n_tests = 0, n_fail = 0;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic        ill;
    } ent_t;
    ent_t q[$];
    int cnt = 0, cnt2 = 0;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .Opcode(Opcode), .Funct3(Funct3), .Funct7(Funct7), .RD1(RD1), .RD2(RD2), .Imm(Imm),
        .flush(flush), .out_ready(out_ready), .out_valid(out_valid), .SrcA(SrcA), .SrcB(SrcB),
        .Operation(Operation), .illegal(illegal), .illegal_count(illegal_count));

    alu_issue_stage #(.CNT_WIDTH(2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready2),
        .Opcode(Opcode), .Funct3(Funct3), .Funct7(Funct7), .RD1(RD1), .RD2(RD2), .Imm(Imm),
        .flush(flush), .out_ready(out_ready), .out_valid(out_valid2), .SrcA(SrcA2), .SrcB(SrcB2),
        .Operation(Operation2), .illegal(illegal2), .illegal_count(illegal_count2));

    // Reference decode, table-driven from the instruction-set rules: returns {illegal, op}.
    function automatic logic [4:0] ref_dec(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
        int base[8] = '{3, 7, 10, 14, 2, 5, 1, 0};
        int br[8]   = '{8, 9, -1, -1, 10, 11, 14, 15};
        int op = 0;
        bit ill = 0;
        if (o == 7'h33) begin
            if (f7 == 7'h00) op = base[f3];
            else if (f7 == 7'h20 && f3 == 3'd0) op = 4;
            else if (f7 == 7'h20 && f3 == 3'd5) op = 6;
            else ill = 1;
        end else if (o == 7'h13) begin
            if (f3 == 3'd1 && f7 != 7'h00) ill = 1;
            else if (f3 == 3'd5) begin
                if (f7 == 7'h00) op = 5;
                else if (f7 == 7'h20) op = 6;
                else ill = 1;
            end else op = base[f3];
        end else if (o == 7'h03 || o == 7'h23) op = 3;
        else if (o == 7'h63) begin
            if (br[f3] < 0) ill = 1; else op = br[f3];
        end else if (o == 7'h67) begin
            if (f3 == 3'd0) op = 12; else ill = 1;
        end else if (o == 7'h37) op = 13;
        else ill = 1;
        if (ill) op = 0;
        return {ill, 4'(op)};
    endfunction

    function automatic logic [31:0] ref_srcb(input logic [6:0] o, input logic [2:0] f3,
                                             input logic [31:0] rd2, input logic [31:0] imm);
        if (o == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) return imm % 32;
        if (o == 7'h13 || o == 7'h03 || o == 7'h23 || o == 7'h37) return imm;
        return rd2;
    endfunction

    function automatic bit model_ready();
`ifdef ALU_ISSUE_SKID_EN
        return q.size() < 2;
`else
        return q.size() == 0 || out_ready;
`endif
    endfunction

    task automatic drive(input logic v, input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b, input logic [31:0] im,
                         input logic fl, input logic ordy);
        in_valid = v; Opcode = o; Funct3 = f3; Funct7 = f7;
        RD1 = a; RD2 = b; Imm = im; flush = fl; out_ready = ordy;
    endtask

    // Advance one clock and update the model; callers are 1 time unit past an edge.
    task automatic tick();
        bit acc, fire;
        ent_t e;
        logic [4:0] d;
        acc = in_valid && model_ready() && !flush;
        fire = q.size() > 0 && out_ready;
        d = ref_dec(Opcode, Funct3, Funct7);
        e = '{a: RD1, b: ref_srcb(Opcode, Funct3, RD2, Imm), op: d[3:0], ill: d[4]};
        @(posedge clk);
        #1;
        if (flush) q.delete();
        else begin
            if (fire) void'(q.pop_front());
            if (acc) begin
                q.push_back(e);
                if (e.ill) begin
                    if (cnt < 255) cnt++;
                    if (cnt2 < 3) cnt2++;
                end
            end
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #2;
        reset = 1'b1;
        q.delete();
        cnt = 0;
        cnt2 = 0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive(0, 7'h0, 3'd0, 7'h0, 0, 0, 0, 0, 1);
        #12;
        n_tests++;
        if ({out_valid, SrcA, SrcB, Operation, illegal, illegal_count} !== 78'd0) begin
            n_fail++;
            $display("FAIL reset_state got v=%b a=%h b=%h op=%h ill=%b cnt=%0d expected all zero",
                     out_valid, SrcA, SrcB, Operation, illegal, illegal_count);
        end
        reset = 1'b1;
        tick();
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_in_ready got %b expected 1", in_ready);
        end
    endtask

    task automatic test_decode();
        drive(1, 7'h33, 3'd0, 7'h20, 32'd10, 32'd3, 32'd0, 0, 1);
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || Operation !== 4'b0100 || SrcA !== 32'd10 || SrcB !== 32'd3) begin
            n_fail++;
            $display("FAIL decode_sub got v=%b op=%b a=%0d b=%0d expected 1 0100 10 3", out_valid, Operation, SrcA, SrcB);
        end
        drive(1, 7'h13, 3'd5, 7'h20, 32'd7, 32'd9, 32'h405, 0, 1);
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || Operation !== 4'b0110 || SrcB !== 32'd5) begin
            n_fail++;
            $display("FAIL decode_srai got v=%b op=%b b=%h expected 1 0110 5", out_valid, Operation, SrcB);
        end
        drive(1, 7'h63, 3'd7, 7'h00, 32'd4, 32'hdead_beef, 32'h10, 0, 1);
        tick();
        n_tests++;
        if (Operation !== 4'b1111 || SrcB !== 32'hdead_beef || illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL decode_bgeu got op=%b b=%h ill=%b expected 1111 deadbeef 0", Operation, SrcB, illegal);
        end
        drive(1, 7'h37, 3'd2, 7'h11, 32'd0, 32'd1, 32'h1234_5000, 0, 1);
        tick();
        n_tests++;
        if (Operation !== 4'b1101 || SrcB !== 32'h1234_5000) begin
            n_fail++;
            $display("FAIL decode_lui got op=%b b=%h expected 1101 12345000", Operation, SrcB);
        end
        drive(0, 7'h0, 3'd0, 7'h0, 0, 0, 0, 0, 1);
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL decode_drain got v=%b expected 0", out_valid);
        end
    endtask

    task automatic test_backpressure();
        bit sent = 0;
        bit exp_rdy;
        drive(1, 7'h33, 3'd0, 7'h00, 32'd1, 32'd5, 32'd0, 0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            drive(!sent, 7'h33, 3'd4, 7'h00, 32'd2, 32'd6, 32'd0, 0, 0);
            #1;
`ifdef ALU_ISSUE_SKID_EN
            exp_rdy = (i == 0);
`else
            exp_rdy = 1'b0;
`endif
            n_tests++;
            if (in_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL bp_in_ready[%0d] got %b expected %b", i, in_ready, exp_rdy);
            end
            if (in_valid && model_ready()) sent = 1;
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || SrcA !== 32'd1 || Operation !== 4'b0011) begin
                n_fail++;
                $display("FAIL bp_hold[%0d] got v=%b a=%0d op=%b expected 1 1 0011", i, out_valid, SrcA, Operation);
            end
        end
        drive(!sent, 7'h33, 3'd4, 7'h00, 32'd2, 32'd6, 32'd0, 0, 1);
        #1;
        if (in_valid && model_ready()) sent = 1;
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || SrcA !== 32'd2 || Operation !== 4'b0010 || !sent) begin
            n_fail++;
            $display("FAIL bp_second got v=%b a=%0d op=%b expected 1 2 0010", out_valid, SrcA, Operation);
        end
        drive(0, 7'h0, 3'd0, 7'h0, 0, 0, 0, 0, 1);
        tick();
        n_tests++;
        if (out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_drain got v=%b expected 0", out_valid);
        end
    endtask

    task automatic test_flush();
        logic [7:0] c0;
        drive(1, 7'h7f, 3'd0, 7'h00, 32'd1, 32'd1, 32'd0, 0, 0);
        tick();
        c0 = illegal_count;
        n_tests++;
        if (illegal !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_setup_illegal got %b expected 1", illegal);
        end
        drive(1, 7'h7f, 3'd1, 7'h00, 32'd3, 32'd3, 32'd0, 1, 0);
        tick();
        n_tests++;
        if (out_valid !== 1'b0 || illegal !== 1'b0 || illegal_count !== c0) begin
            n_fail++;
            $display("FAIL flush_clear got v=%b ill=%b cnt=%0d expected 0 0 %0d", out_valid, illegal, illegal_count, c0);
        end
        drive(1, 7'h13, 3'd0, 7'h55, 32'd8, 32'd0, 32'hffff_fff0, 0, 1);
        tick();
        n_tests++;
        if (out_valid !== 1'b1 || Operation !== 4'b0011 || SrcB !== 32'hffff_fff0 || illegal_count !== c0) begin
            n_fail++;
            $display("FAIL flush_next got v=%b op=%b b=%h cnt=%0d expected 1 0011 fffffff0 %0d",
                     out_valid, Operation, SrcB, illegal_count, c0);
        end
        drive(0, 7'h0, 3'd0, 7'h0, 0, 0, 0, 0, 1);
        tick();
    endtask

    task automatic test_illegal();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1, 7'h7f, 3'(i), 7'h00, 32'(i), 32'd0, 32'd0, 0, 1);
            tick();
            n_tests++;
            if (out_valid !== 1'b1 || illegal !== 1'b1 || Operation !== 4'b0000) begin
                n_fail++;
                $display("FAIL illegal_flag[%0d] got v=%b ill=%b op=%b expected 1 1 0000", i, out_valid, illegal, Operation);
            end
            if (i == 2) begin
                n_tests++;
                if (illegal_count !== 8'd3) begin
                    n_fail++;
                    $display("FAIL illegal_count3 got %0d expected 3", illegal_count);
                end
            end
        end
        n_tests++;
        if (illegal_count2 !== 2'd3 || illegal_count !== 8'd5) begin
            n_fail++;
            $display("FAIL illegal_saturate got narrow=%0d wide=%0d expected 3 5", illegal_count2, illegal_count);
        end
        drive(0, 7'h0, 3'd0, 7'h0, 0, 0, 0, 0, 1);
        tick();
    endtask

    task automatic test_async_reset();
        drive(1, 7'h33, 3'd6, 7'h00, 32'h55, 32'h66, 32'd0, 0, 0);
        tick();
        drive(1, 7'h33, 3'd7, 7'h00, 32'h77, 32'h88, 32'd0, 0, 0);
        #2;
        reset = 1'b0;
        #1;
        n_tests++;
        if ({out_valid, SrcA, SrcB, Operation, illegal, illegal_count} !== 78'd0) begin
            n_fail++;
            $display("FAIL async_reset got v=%b a=%h b=%h op=%h ill=%b cnt=%0d expected all zero",
                     out_valid, SrcA, SrcB, Operation, illegal, illegal_count);
        end
        drive(0, 7'h0, 3'd0, 7'h0, 0, 0, 0, 0, 0);
        #1;
        reset = 1'b1;
        q.delete();
        cnt = 0;
        cnt2 = 0;
        #1;
        n_tests++;
        if (in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL async_reset_ready got %b expected 1", in_ready);
        end
        tick();
    endtask

    task automatic test_random();
        logic [6:0] opcs[9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67, 7'h37, 7'h7f, 7'h00};
        logic [6:0] f7s[3] = '{7'h00, 7'h20, 7'h00};
        logic [6:0] o, f7;
        for (int i = 0; i < 400; i++) begin
            o = opcs[$urandom_range(8)];
            if (o == 7'h00) o = 7'($urandom);
            f7 = f7s[$urandom_range(2)];
            if ($urandom_range(7) == 0) f7 = 7'($urandom);
            drive(1'($urandom_range(3) != 0), o, 3'($urandom), f7, $urandom, $urandom, $urandom,
                  $urandom_range(19) == 0, $urandom_range(2) != 0);
            #1;
            n_tests++;
            if (in_ready !== model_ready()) begin
                n_fail++;
                $display("FAIL rand_in_ready[%0d] got %b expected %b", i, in_ready, model_ready());
            end
            tick();
            n_tests++;
            if (out_valid !== (q.size() > 0)) begin
                n_fail++;
                $display("FAIL rand_valid[%0d] got %b expected %b", i, out_valid, q.size() > 0);
            end else if (q.size() > 0) begin
                n_tests++;
                if (SrcA !== q[0].a || SrcB !== q[0].b || Operation !== q[0].op || illegal !== q[0].ill) begin
                    n_fail++;
                    $display("FAIL rand_data[%0d] got a=%h b=%h op=%b ill=%b expected a=%h b=%h op=%b ill=%b",
                             i, SrcA, SrcB, Operation, illegal, q[0].a, q[0].b, q[0].op, q[0].ill);
                end
            end
            n_tests++;
            if (illegal_count !== 8'(cnt) || illegal_count2 !== 2'(cnt2)) begin
                n_fail++;
                $display("FAIL rand_count[%0d] got %0d/%0d expected %0d/%0d",
                         i, illegal_count, illegal_count2, cnt, cnt2);
            end
        end
    endtask

    initial begin
        test_reset();
        test_decode();
        test_backpressure();
        test_flush();
        test_illegal();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Producer end of the ALU operand/operation interface. Decodes RV32I instruction fields into the 4-bit ALU Operation code and selects SrcA/SrcB.
- Registers the result in a valid/ready pipeline stage with stall and flush.
- Sits between register-file read/immediate generation and the combinational ALU, and drives the ALU inputs directly.

Parameters:
- DATA_WIDTH, 32, operand width
- OPCODE_LENGTH, 4, ALU Operation code width
- CNT_WIDTH, 8, illegal-instruction counter width

Ports:
- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  upstream has a decoded instruction
- in_ready  output  1  stage accepts this cycle
- Opcode  input  7  instr[6:0]
- Funct3  input  3  instr[14:12]
- Funct7  input  7  instr[31:25]
- RD1  input  DATA_WIDTH  rs1 value
- RD2  input  DATA_WIDTH  rs2 value
- Imm  input  DATA_WIDTH  sign-extended immediate
- flush  input  1  kill held and incoming instruction
- out_ready  input  1  downstream accepts
- out_valid  output  1  SrcA/SrcB/Operation valid
- SrcA  output  DATA_WIDTH  ALU operand A
- SrcB  output  DATA_WIDTH  ALU operand B
- Operation  output  OPCODE_LENGTH  ALU operation code
- illegal  output  1  held instruction is undecodable
- illegal_count  output  CNT_WIDTH  saturating count of accepted illegal instructions

Behaviour:
- Reset (reset=0, async): out_valid=0, SrcA=0, SrcB=0, Operation=4'b0000, illegal=0, illegal_count=0. in_ready=1 after release.
- Handshake:
  - Transfer in occurs when in_valid&&in_ready.
  - Transfer out occurs when out_valid&&out_ready.
  - in_ready = !out_valid || out_ready (combinational).
  - Latency 1 cycle, full throughput.
  - While out_valid=1 and out_ready=0, all outputs are held stable.
- Flush:
  - Next edge clears out_valid and discards any simultaneous in_valid.
  - Flush has priority over capture and over out_ready.
  - Data registers may keep stale values; illegal is cleared.
- SrcA: always RD1.
- SrcB: Imm for opcodes 0010011, 0000011, 0100011 and 0110111; RD2 otherwise.
  - Shift-immediate case: SrcB = {zeros, Imm[4:0]}.
- Operation decode:
  - R-type 0110011:
    - f3=000: f7=0000000 ADD 0011; f7=0100000 SUB 0100
    - f3=001 SLL 0111
    - f3=010 SLT 1010
    - f3=011 SLTU 1110
    - f3=100 XOR 0010
    - f3=101: f7=0000000 SRL 0101; f7=0100000 SRA 0110
    - f3=110 OR 0001
    - f3=111 AND 0000
    - Any other f7 is illegal.
  - I-type 0010011:
    - f3=000 ADDI 0011
    - f3=010 SLTI 1010
    - f3=011 SLTIU 1110
    - f3=100 XORI 0010
    - f3=110 ORI 0001
    - f3=111 ANDI 0000
    - f3=001 SLLI 0111, only if f7=0000000
    - f3=101: SRLI 0101 (f7=0000000), SRAI 0110 (f7=0100000)
  - Load 0000011 and store 0100011: 0011.
  - Branch 1100011:
    - f3=000 BEQ 1000
    - f3=001 BNE 1001
    - f3=100 BLT 1010
    - f3=101 BGE 1011
    - f3=110 BLTU 1110
    - f3=111 BGEU 1111
    - f3=010 or 011 is illegal.
  - JALR 1100111 (f3=000): 1100.
  - LUI 0110111: 1101.
  - Anything else: illegal.
- Illegal instructions:
  - Operation=0000 and illegal=1; the instruction is still passed (out_valid=1).
  - illegal_count increments once per accepted illegal instruction and saturates at all-ones.
  - Flushed instructions are not counted.
- Simultaneous accept-in and transfer-out: the new instruction replaces the old one; out_valid stays 1.
- Reset mid-transfer: state clears immediately; no partial output.

Optional Feature:
- Macro: ALU_ISSUE_SKID_EN.
- Defined:
  - Adds a one-entry skid register. in_ready becomes a registered signal equal to !skid_full, with no combinational path from out_ready.
  - When the output is stalled and the stage accepts, the new entry goes to the skid register.
  - The skid entry moves to the output on the next out transfer.
  - Ordering is preserved; flush clears both entries.
  - Reset: skid empty, in_ready=1.
- Undefined: single register with combinational in_ready as above.

Test Plan:
- Decode sweep with out_ready=1:
  - Opcode 0110011, f3=000, f7=0100000, RD1=10, RD2=3 -> next cycle Operation=0100, SrcA=10, SrcB=3, out_valid=1.
  - SRAI: Opcode 0010011, f3=101, f7=0100000, Imm=32'h405 -> Operation=0110, SrcB=5.
- Branches and LUI:
  - BGEU (1100011, f3=111) -> 1111, SrcB=RD2.
  - LUI Imm=32'h12345000 -> 1101, SrcB=32'h12345000.
- Backpressure:
  - Send ADD (RD1=1), then XOR (RD1=2) with out_ready=0 for 3 cycles -> ADD outputs held; in_ready=0 (1 for one extra accept with skid).
  - Release -> ADD then XOR delivered in order, none lost.
- Flush:
  - Flush while in_valid=1 and an entry is held -> next cycle out_valid=0.
  - The following instruction decodes normally; illegal_count unchanged.
- Illegal:
  - Opcode 1111111 x3 -> each yields illegal=1, Operation=0000; illegal_count=3.
  - With CNT_WIDTH=2, 5 illegals -> count=3.
- Async reset asserted mid-stall -> all outputs 0 immediately without a clock edge. After release, in_ready=1.
